// File: rtl/gomoku_pkg.sv
// rtl/gomoku_pkg.sv - shared types and scan direction table for the gomoku state engine
package gomoku_pkg;
  typedef enum logic [1:0] {
    RSP_PLACED  = 2'd0,
    RSP_UNDONE  = 2'd1,
    RSP_ILLEGAL = 2'd2,
    RSP_REFUSED = 2'd3
  } rsp_code_e;

  typedef enum logic [1:0] {
    GS_PLAYING = 2'd0,
    GS_P0_WIN  = 2'd1,
    GS_P1_WIN  = 2'd2,
    GS_DRAW    = 2'd3
  } game_status_e;

  typedef enum logic [1:0] {
    DIR_H = 2'd0,
    DIR_V = 2'd1,
    DIR_D = 2'd2,
    DIR_A = 2'd3
  } dir_e;

  // Forward step per direction; the opposite side of the run uses the negated step.
  localparam int DIR_DROW [4] = '{0, 1, 1, 1};
  localparam int DIR_DCOL [4] = '{1, 0, 1, -1};
endpackage

// File: rtl/gomoku_state_engine_if.sv
// rtl/gomoku_state_engine_if.sv - command/response handshake between move source and engine
interface gomoku_state_engine_if #(
  parameter int AW = 7
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_undo;
  logic [AW-1:0] cmd_addr;
  logic          rsp_valid;
  logic [1:0]    rsp_code;

  modport master (output cmd_valid, cmd_undo, cmd_addr, input cmd_ready, rsp_valid, rsp_code);
  modport slave  (input cmd_valid, cmd_undo, cmd_addr, output cmd_ready, rsp_valid, rsp_code);
endinterface

// File: rtl/gomoku_run_counter.sv
// rtl/gomoku_run_counter.sv - counts same-colour stones either side of an origin along one direction
module gomoku_run_counter
  import gomoku_pkg::*;
#(
  parameter int N = 11,
  parameter int K = 5
) (
  input  logic [N*N-1:0]         plane,
  input  logic [$clog2(N)-1:0]   row,
  input  logic [$clog2(N)-1:0]   col,
  input  dir_e                   dir,
  output logic [$clog2(K)-1:0]   left,
  output logic [$clog2(K)-1:0]   right,
  output logic [N*N-1:0]         run_mask
);
  localparam int AW = $clog2(N*N);

  always_comb begin
    int  r;
    int  c;
    logic go;
    left     = '0;
    right    = '0;
    run_mask = '0;
    run_mask[AW'(int'(row) * N + int'(col))] = 1'b1;

    // Each side stops at the first empty/foreign cell or at the board edge, so rows never wrap.
    go = 1'b1;
    for (int s = 1; s < K; s++) begin
      r = int'(row) + s * DIR_DROW[dir];
      c = int'(col) + s * DIR_DCOL[dir];
      if (go && r >= 0 && r < N && c >= 0 && c < N && plane[AW'(r * N + c)]) begin
        right = right + 1'b1;
        run_mask[AW'(r * N + c)] = 1'b1;
      end else begin
        go = 1'b0;
      end
    end

    go = 1'b1;
    for (int s = 1; s < K; s++) begin
      r = int'(row) - s * DIR_DROW[dir];
      c = int'(col) - s * DIR_DCOL[dir];
      if (go && r >= 0 && r < N && c >= 0 && c < N && plane[AW'(r * N + c)]) begin
        left = left + 1'b1;
        run_mask[AW'(r * N + c)] = 1'b1;
      end else begin
        go = 1'b0;
      end
    end
  end
endmodule

// File: rtl/gomoku_state_engine.sv
// rtl/gomoku_state_engine.sv - board/history/status owner with a four-cycle win scan per placement
module gomoku_state_engine
  import gomoku_pkg::*;
#(
  parameter int N  = 11,
  parameter int K  = 5,
  parameter int AW = $clog2(N*N),
  parameter int CW = $clog2(N*N+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  gomoku_state_engine_if.slave  cmd,
  output logic                  player,
  output logic [1:0]            game_status,
  output logic [N*N-1:0]        board0,
  output logic [N*N-1:0]        board1,
  output logic [N*N-1:0]        win_mask,
  output logic [CW-1:0]         move_count,
  output logic [AW-1:0]         last_addr
);
  localparam int CELLS = N * N;
  localparam int RW    = $clog2(N);
  localparam int CNW   = $clog2(K);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESP} state_e;

  state_e        state, state_nx;
  dir_e          dir;
  logic          win_seen;
  rsp_code_e     code_q, idle_code;
  logic          do_place, do_undo, in_range, occupied;
  logic [AW-1:0] hist [CELLS];
  logic [AW-1:0] prev_addr;

  logic [RW-1:0]  org_row, org_col;
  logic [CNW-1:0] run_left, run_right;
  logic [CNW:0]   run_len;
  logic [N*N-1:0] run_mask;
  logic           win_dir;

  assign in_range  = int'(cmd.cmd_addr) < CELLS;
  assign occupied  = board0[cmd.cmd_addr] | board1[cmd.cmd_addr];
  assign prev_addr = (move_count > CW'(1)) ? hist[AW'(move_count - 2'd2)] : '0;

  assign cmd.cmd_ready = (state == S_IDLE);
  assign cmd.rsp_valid = (state == S_RESP);
  assign cmd.rsp_code  = code_q;

  assign org_row = RW'(int'(last_addr) / N);
  assign org_col = RW'(int'(last_addr) % N);

  // During SCAN the side to move is still the player who just placed.
  gomoku_run_counter #(.N(N), .K(K)) u_run (
    .plane    (player ? board1 : board0),
    .row      (org_row),
    .col      (org_col),
    .dir      (dir),
    .left     (run_left),
    .right    (run_right),
    .run_mask (run_mask)
  );

  assign run_len = (CNW+1)'(run_left) + (CNW+1)'(run_right) + 1'b1;
  assign win_dir = int'(run_len) >= K;

  always_comb begin
    do_place  = 1'b0;
    do_undo   = 1'b0;
    idle_code = RSP_REFUSED;
    state_nx  = state;
    if (cmd.cmd_undo) begin
      if (move_count != '0) begin
        do_undo   = 1'b1;
        idle_code = RSP_UNDONE;
      end
    end else if (game_status != GS_PLAYING) begin
      idle_code = RSP_REFUSED;
    end else if (!in_range || occupied) begin
      idle_code = RSP_ILLEGAL;
    end else begin
      do_place  = 1'b1;
      idle_code = RSP_PLACED;
    end

    case (state)
      S_IDLE:  if (cmd.cmd_valid) state_nx = do_place ? S_SCAN : S_RESP;
      S_SCAN:  if (dir == DIR_A) state_nx = S_RESP;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      board0      <= '0;
      board1      <= '0;
      win_mask    <= '0;
      move_count  <= '0;
      last_addr   <= '0;
      player      <= 1'b0;
      game_status <= GS_PLAYING;
      dir         <= DIR_H;
      win_seen    <= 1'b0;
      code_q      <= RSP_PLACED;
    end else begin
      case (state)
        S_IDLE: if (cmd.cmd_valid) begin
          code_q <= idle_code;
          if (do_place) begin
            if (player) board1[cmd.cmd_addr] <= 1'b1;
            else        board0[cmd.cmd_addr] <= 1'b1;
            hist[AW'(move_count)] <= cmd.cmd_addr;
            move_count <= move_count + 1'b1;
            last_addr  <= cmd.cmd_addr;
            win_mask   <= '0;
            dir        <= DIR_H;
            win_seen   <= 1'b0;
          end else if (do_undo) begin
            // The last stone belongs to the side that is not to move.
            if (player) board0[last_addr] <= 1'b0;
            else        board1[last_addr] <= 1'b0;
            move_count  <= move_count - 1'b1;
            last_addr   <= prev_addr;
            player      <= ~player;
            win_mask    <= '0;
            game_status <= GS_PLAYING;
          end
        end
        S_SCAN: begin
          dir <= dir_e'(dir + 2'd1);
          if (win_dir) begin
            win_mask <= win_mask | run_mask;
            win_seen <= 1'b1;
          end
          if (dir == DIR_A) begin
            if (win_seen || win_dir)           game_status <= player ? GS_P1_WIN : GS_P0_WIN;
            else if (move_count == CW'(CELLS)) game_status <= GS_DRAW;
            else                               game_status <= GS_PLAYING;
            player <= ~player;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gomoku_state_engine.sv
// tb/tb_gomoku_state_engine.sv - scoreboard bench for gomoku_state_engine (11x11/K5 and 5x5/K5)
module tb_gomoku_state_engine;
  localparam int NA = 11, KA = 5, NB = 5, KB = 5;
  localparam int AWA = $clog2(NA*NA), CWA = $clog2(NA*NA+1);
  localparam int AWB = $clog2(NB*NB), CWB = $clog2(NB*NB+1);

  logic clk = 1'b0;
  logic a_rst, b_rst;
  always #5 clk = ~clk;

  gomoku_state_engine_if #(.AW(AWA)) a_if ();
  gomoku_state_engine_if #(.AW(AWB)) b_if ();

  logic             a_player, b_player;
  logic [1:0]       a_gs, b_gs;
  logic [NA*NA-1:0] a_b0, a_b1, a_wm;
  logic [NB*NB-1:0] b_b0, b_b1, b_wm;
  logic [CWA-1:0]   a_mc;
  logic [CWB-1:0]   b_mc;
  logic [AWA-1:0]   a_last;
  logic [AWB-1:0]   b_last;

  gomoku_state_engine #(.N(NA), .K(KA)) dut_a (
    .clk(clk), .rst(a_rst), .cmd(a_if), .player(a_player), .game_status(a_gs),
    .board0(a_b0), .board1(a_b1), .win_mask(a_wm), .move_count(a_mc), .last_addr(a_last)
  );
  gomoku_state_engine #(.N(NB), .K(KB)) dut_b (
    .clk(clk), .rst(b_rst), .cmd(b_if), .player(b_player), .game_status(b_gs),
    .board0(b_b0), .board1(b_b1), .win_mask(b_wm), .move_count(b_mc), .last_addr(b_last)
  );

  int         checks = 0;
  int         failures = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_code;
  int         obs_lat;
  logic       obs_rdy1;
  int         obs_mc1;

  task automatic drive(input bit sel, input bit undo, input int addr);
    int k;
    k = 0;
    while (!(sel ? b_if.cmd_ready : a_if.cmd_ready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (sel) begin b_if.cmd_valid = 1'b1; b_if.cmd_undo = undo; b_if.cmd_addr = AWB'(addr); end
    else     begin a_if.cmd_valid = 1'b1; a_if.cmd_undo = undo; a_if.cmd_addr = AWA'(addr); end
    @(posedge clk);
    #1;
    a_if.cmd_valid = 1'b0;
    b_if.cmd_valid = 1'b0;
    obs_code = 2'bxx;
    obs_lat  = -1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0) begin
        obs_rdy1 = sel ? b_if.cmd_ready : a_if.cmd_ready;
        obs_mc1  = sel ? int'(b_mc) : int'(a_mc);
      end
      if (sel ? b_if.rsp_valid : a_if.rsp_valid) begin
        obs_code = sel ? b_if.rsp_code : a_if.rsp_code;
        obs_lat  = k + 1;
        break;
      end
    end
  endtask

  task automatic reset_a();
    @(negedge clk); a_rst = 1'b1;
    @(negedge clk); @(negedge clk); a_rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (a_mc !== '0 || a_gs !== 2'd0 || a_player !== 1'b0) begin failures++;
      $display("FAIL reset_status mc=%0d gs=%0d player=%0d want 0/0/0", a_mc, a_gs, a_player); end
    checks++; if (a_b0 !== '0 || a_b1 !== '0 || a_wm !== '0 || a_last !== '0) begin failures++;
      $display("FAIL reset_planes b0=%h b1=%h wm=%h last=%0d want all 0", a_b0, a_b1, a_wm, a_last); end
    checks++; if (a_if.cmd_ready !== 1'b1 || a_if.rsp_valid !== 1'b0) begin failures++;
      $display("FAIL reset_handshake ready=%b rsp_valid=%b want 1/0", a_if.cmd_ready, a_if.rsp_valid); end
  endtask

  task automatic test_undo_empty();
    logic [1:0] e;
    exp_q.push_back(2'd3); drive(0, 1, 0); e = exp_q.pop_front();
    checks++; if (obs_code !== e || obs_lat != 1) begin failures++;
      $display("FAIL undo_empty code=%0d lat=%0d want code=%0d lat=1", obs_code, obs_lat, e); end
    checks++; if (a_mc !== '0) begin failures++;
      $display("FAIL undo_empty_mc got=%0d want 0", a_mc); end
  endtask

  task automatic test_win_horizontal();
    int mv[9];
    logic [1:0] e;
    logic [NA*NA-1:0] m;
    mv = '{0, 11, 1, 12, 2, 13, 3, 14, 4};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(2'd0); drive(0, 0, mv[i]); e = exp_q.pop_front();
      checks++; if (obs_code !== e || obs_lat != 5) begin failures++;
        $display("FAIL hwin_move%0d code=%0d lat=%0d want code=%0d lat=5", i, obs_code, obs_lat, e); end
      checks++; if (obs_mc1 != i + 1 || obs_rdy1 !== 1'b0) begin failures++;
        $display("FAIL hwin_t1_%0d mc=%0d ready=%b want mc=%0d ready=0", i, obs_mc1, obs_rdy1, i + 1); end
      if (i < 8) begin
        checks++; if (a_gs !== 2'd0) begin failures++;
          $display("FAIL hwin_gs%0d got=%0d want 0", i, a_gs); end
      end
    end
    m = '0;
    for (int i = 0; i < 5; i++) m[i] = 1'b1;
    checks++; if (a_gs !== 2'd1 || a_player !== 1'b1) begin failures++;
      $display("FAIL hwin_status gs=%0d player=%0d want 1/1", a_gs, a_player); end
    checks++; if (a_wm !== m) begin failures++;
      $display("FAIL hwin_mask got=%h want=%h", a_wm, m); end
  endtask

  task automatic test_refused_then_undo();
    logic [1:0] e;
    exp_q.push_back(2'd3); drive(0, 0, 50); e = exp_q.pop_front();
    checks++; if (obs_code !== e || obs_lat != 1 || a_mc !== CWA'(9)) begin failures++;
      $display("FAIL refused_place code=%0d lat=%0d mc=%0d want code=%0d lat=1 mc=9", obs_code, obs_lat, a_mc, e); end
    exp_q.push_back(2'd1); drive(0, 1, 0); e = exp_q.pop_front();
    checks++; if (obs_code !== e || obs_lat != 1) begin failures++;
      $display("FAIL undo_win code=%0d lat=%0d want code=%0d lat=1", obs_code, obs_lat, e); end
    checks++; if (a_gs !== 2'd0 || a_wm !== '0 || a_b0[4] !== 1'b0 || a_player !== 1'b0) begin failures++;
      $display("FAIL undo_win_state gs=%0d wm=%h cell4=%b player=%0d want 0/0/0/0", a_gs, a_wm, a_b0[4], a_player); end
    checks++; if (a_mc !== CWA'(8) || a_last !== AWA'(14)) begin failures++;
      $display("FAIL undo_win_hist mc=%0d last=%0d want 8/14", a_mc, a_last); end
  endtask

  task automatic test_illegal();
    logic [1:0] e;
    exp_q.push_back(2'd0); drive(0, 0, 60); e = exp_q.pop_front();
    checks++; if (obs_code !== e || a_b0[60] !== 1'b1) begin failures++;
      $display("FAIL illegal_first code=%0d cell=%b want code=%0d cell=1", obs_code, a_b0[60], e); end
    exp_q.push_back(2'd2); drive(0, 0, 60); e = exp_q.pop_front();
    checks++; if (obs_code !== e || obs_lat != 1 || a_mc !== CWA'(1) || a_player !== 1'b1) begin failures++;
      $display("FAIL illegal_occupied code=%0d lat=%0d mc=%0d player=%0d want code=%0d lat=1 mc=1 player=1", obs_code, obs_lat, a_mc, a_player, e); end
    exp_q.push_back(2'd2); drive(0, 0, 121); e = exp_q.pop_front();
    checks++; if (obs_code !== e || a_mc !== CWA'(1) || a_b1 !== '0) begin failures++;
      $display("FAIL illegal_range code=%0d mc=%0d b1=%h want code=%0d mc=1 b1=0", obs_code, a_mc, a_b1, e); end
  endtask

  task automatic test_no_wrap();
    int mv[9];
    logic [1:0] e;
    mv = '{8, 100, 9, 101, 10, 102, 11, 103, 12};
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(2'd0); drive(0, 0, mv[i]); e = exp_q.pop_front();
      checks++; if (obs_code !== e || a_gs !== 2'd0) begin failures++;
        $display("FAIL nowrap_move%0d code=%0d gs=%0d want code=%0d gs=0", i, obs_code, a_gs, e); end
    end
    checks++; if (a_wm !== '0 || a_mc !== CWA'(9)) begin failures++;
      $display("FAIL nowrap_final wm=%h mc=%0d want 0/9", a_wm, a_mc); end
  endtask

  task automatic test_anti_diag();
    int mv[9];
    logic [1:0] e;
    logic [NA*NA-1:0] m;
    mv = '{4, 110, 14, 112, 24, 114, 34, 116, 44};
    m = '0;
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(2'd0); drive(0, 0, mv[i]); e = exp_q.pop_front();
      checks++; if (obs_code !== e || obs_lat != 5) begin failures++;
        $display("FAIL adiag_move%0d code=%0d lat=%0d want code=%0d lat=5", i, obs_code, obs_lat, e); end
      if (i % 2 == 0) m[mv[i]] = 1'b1;
    end
    checks++; if (a_gs !== 2'd1 || a_wm !== m) begin failures++;
      $display("FAIL adiag_win gs=%0d wm=%h want gs=1 wm=%h", a_gs, a_wm, m); end
  endtask

  task automatic test_draw_and_abort();
    int p0[13];
    int p1[12];
    int addr;
    logic [1:0] e;
    logic seen;
    p0 = '{0, 1, 4, 7, 8, 10, 11, 14, 17, 18, 20, 21, 24};
    p1 = '{2, 3, 5, 6, 9, 12, 13, 15, 16, 19, 22, 23};
    for (int i = 0; i < 25; i++) begin
      addr = (i % 2 == 0) ? p0[i / 2] : p1[i / 2];
      exp_q.push_back(2'd0); drive(1, 0, addr); e = exp_q.pop_front();
      checks++; if (obs_code !== e || obs_lat != 5) begin failures++;
        $display("FAIL draw_move%0d code=%0d lat=%0d want code=%0d lat=5", i, obs_code, obs_lat, e); end
      if (i < 24) begin
        checks++; if (b_gs !== 2'd0) begin failures++;
          $display("FAIL draw_gs%0d got=%0d want 0", i, b_gs); end
      end
    end
    checks++; if (b_gs !== 2'd3 || b_mc !== CWB'(25)) begin failures++;
      $display("FAIL draw_final gs=%0d mc=%0d want 3/25", b_gs, b_mc); end
    exp_q.push_back(2'd1); drive(1, 1, 0); e = exp_q.pop_front();
    checks++; if (obs_code !== e || b_gs !== 2'd0 || b_mc !== CWB'(24) || b_player !== 1'b0) begin failures++;
      $display("FAIL draw_undo code=%0d gs=%0d mc=%0d player=%0d want code=%0d gs=0 mc=24 player=0", obs_code, b_gs, b_mc, b_player, e); end
    @(negedge clk);
    b_if.cmd_valid = 1'b1; b_if.cmd_undo = 1'b0; b_if.cmd_addr = AWB'(24);
    @(posedge clk); #1; b_if.cmd_valid = 1'b0;
    @(negedge clk);
    checks++; if (b_mc !== CWB'(25) || b_if.cmd_ready !== 1'b0) begin failures++;
      $display("FAIL abort_scan mc=%0d ready=%b want 25/0", b_mc, b_if.cmd_ready); end
    b_rst = 1'b1;
    @(posedge clk); #1; b_rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_if.rsp_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin failures++;
      $display("FAIL abort_rsp got rsp_valid=%b want 0", seen); end
    checks++; if (b_mc !== '0 || b_b0 !== '0 || b_b1 !== '0 || b_wm !== '0 || b_gs !== 2'd0 || b_player !== 1'b0 || b_last !== '0) begin failures++;
      $display("FAIL abort_state mc=%0d b0=%h b1=%h wm=%h gs=%0d player=%0d last=%0d want all 0", b_mc, b_b0, b_b1, b_wm, b_gs, b_player, b_last); end
    checks++; if (b_if.cmd_ready !== 1'b1) begin failures++;
      $display("FAIL abort_ready got=%b want 1", b_if.cmd_ready); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_if.cmd_valid = 1'b0; a_if.cmd_undo = 1'b0; a_if.cmd_addr = '0;
    b_if.cmd_valid = 1'b0; b_if.cmd_undo = 1'b0; b_if.cmd_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_undo_empty();
    test_win_horizontal();
    test_refused_then_undo();
    reset_a();
    test_illegal();
    reset_a();
    test_no_wrap();
    reset_a();
    test_anti_diag();
    test_draw_and_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gomoku_state_engine.md
# gomoku_state_engine

Parametrised successor of the two-player board/state pair for N×N k-in-a-row games. Holds both players' stone planes, the move history and the game status. Validates each command and places or undoes stones. After each placement it runs a multi-cycle win scan centred on the new stone, instead of a full-board combinational check. It sits between the move-command source (host/UI) and the NNUE scorer, and it is the only block that writes the board.

## Interface
- N, 11, board side length (5..15)
- K, 5, stones in a row needed to win (3..N)
- AW, $clog2(N*N), cell address width; addr = row*N + col
- CW, $clog2(N*N+1), move-count width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  engine can accept a command (high only in IDLE)
- cmd_undo  in  1  1 = undo last move, 0 = place stone
- cmd_addr  in  AW  target cell; ignored for undo
- rsp_valid  out  1  one-cycle pulse, command finished
- rsp_code  out  2  0 PLACED, 1 UNDONE, 2 ILLEGAL (occupied or addr ≥ N*N), 3 REFUSED (place while game over, or undo with empty history)
- player  out  1  side to move
- game_status  out  2  0 playing, 1 p0 win, 2 p1 win, 3 draw
- board0, board1  out  N*N  stone planes, bit index = addr
- win_mask  out  N*N  cells of every winning run through the last stone
- move_count  out  CW  stones on board
- last_addr  out  AW  address of the most recent stone; 0 if history is empty

## Operation
- FSM states: IDLE, SCAN, RESP.
- IDLE, command accepted (cmd_valid & cmd_ready):
  - Undo, history non-empty: pop history, clear the cell in the owner's plane, toggle player, clear win_mask, set game_status to 0, decrement move_count → RESP (code 1).
  - Undo, history empty: → RESP (code 3), no state change.
  - Place, game_status ≠ 0: → RESP (code 3), no state change.
  - Place, addr out of range or cell occupied: → RESP (code 2), no state change.
  - Otherwise: set the bit in the current player's plane, push addr to history, increment move_count, dir := 0 → SCAN.
- SCAN, one direction per cycle; dir 0 = horizontal, 1 = vertical, 2 = diagonal, 3 = anti-diagonal:
  - Count same-colour stones on each side of last_addr, up to K-1 per side, stopping at the board edge. Row and column never wrap.
  - If 1 + left + right ≥ K, OR the full contiguous run into win_mask. Overlines win.
  - After dir 3 → RESP.
- RESP:
  - After a placement, update game_status: win → 1 + player; else if move_count == N*N → 3; else 0. Then toggle player.
  - Assert rsp_valid with the code, then return to IDLE.
- History is a LIFO of depth N*N that stores addresses only. Owner parity is implicit: move i belongs to player i mod 2. A full history is impossible while N*N cells exist.
- Undo after a win or draw is legal and restores play. This is the reason undo refusal is keyed on empty history and not on game_status.

## Timing
- Reset values: board planes, win_mask, move_count, last_addr, player, game_status, rsp_valid all 0; FSM in IDLE; cmd_ready = 1 from the first cycle after rst deasserts.
- Accepted placement at edge T: plane bit and move_count visible at T+1; SCAN occupies T+1..T+4; rsp_valid, game_status, player and win_mask updated at T+5; cmd_ready returns high at T+6.
- Undo or reject at edge T: state changes and rsp_valid at T+1; cmd_ready high at T+2.
- cmd_ready is low from acceptance until the cycle after rsp_valid. cmd_* are ignored while cmd_ready is low.
- rst mid-SCAN or mid-RESP aborts the command: no rsp_valid, and all state returns to reset values on the next edge.

## Structure
- Package gomoku_pkg: rsp_code_e, game_status_e, dir_e, per-direction (drow, dcol) constant table.
- Sub-module gomoku_run_counter: combinational. Takes a plane, origin row/col and a direction; returns left/right counts (saturating at K-1) and an N*N run mask. It is instantiated once and shared across SCAN cycles.
- The engine holds the FSM, planes, history RAM/regs, counters and status.

## Test plan
- N=11, K=5: p0 places 0,1,2,3; p1 places 11,12,13,14 → game_status 0. p0 places 4 → rsp PLACED at T+5, game_status 1, win_mask bits 0–4 set.
- Place at addr 60 twice → second rsp_code 2, move_count unchanged, player unchanged. Place at addr 121 → rsp_code 2.
- After a p0 win, place anything → code 3. Then undo → code 1, game_status 0, win_mask 0, cell cleared, player = 0.
- Undo immediately after reset → code 3 at T+1, move_count 0.
- Horizontal run cols 8,9,10 of row 0 plus col 0,1 of row 1 → no win; this checks no row wrap. Anti-diagonal 4,14,24,34,44 → p0 win.
- N=5, K=5: fill 25 cells in a pattern with no winning line → game_status 3 on the 25th rsp. Assert rst during that move's SCAN → no rsp, all outputs 0.
